// File: rtl/ddf_pick_nflux.sv
// ddf_pick_nflux: multi-flux DDF PICK actor.
// Tagged data and control (NDA) tokens land in per-flux FIFOs. A control token
// of payload K selects its flux and makes the actor reduce the next K data
// tokens of that flux (sum modulo 2^DATA_WIDTH or unsigned max) into one tagged
// output token. Fluxes are granted round-robin and a grant is held until its
// result has been written downstream.
//
// Handshake: an input token is accepted on a cycle with its write strobe high
// and the addressed in_port_full*[f] low (full comes from the registered count,
// so a pop in the same cycle does not make room). A write to a full FIFO is
// dropped and recorded in the sticky overflow[f]. Downstream, out_port_write is
// the valid and !out_port_full the ready; the token transfers on a cycle where
// both hold, and out_port_dataout stays stable until then.

// Per-flux FIFO with registered occupancy; no fall-through.
module ddf_pick_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic         drop
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign drop    = wr_en && full;
  assign rd_data = mem[rp_q];

  // Pointer and occupancy update; a simultaneous push and pop keeps the count.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) wp_d = wp_q + AW'(1);
    if (pop)  rp_d = rp_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= wr_data;
  end
endmodule

module ddf_pick_nflux #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = $clog2(FLUX),
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH,
  parameter int DEPTH      = 8,
  parameter int MODE       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_port_write,
  input  logic [WIDTH-1:0] in_port_datain,
  output logic [FLUX-1:0]  in_port_full,
  input  logic             in_port_write_nda,
  input  logic [WIDTH-1:0] in_port_datain_nda,
  output logic [FLUX-1:0]  in_port_full_nda,
  output logic             out_port_write,
  output logic [WIDTH-1:0] out_port_dataout,
  input  logic             out_port_full,
  output logic [FLUX-1:0]  overflow,
  output logic [1:0]       dbg_state
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;

  logic [TAG_WIDTH-1:0]  d_tag, n_tag;
  logic [FLUX-1:0]       d_full, d_empty, d_pop, d_drop;
  logic [FLUX-1:0]       n_full, n_empty, n_pop, n_drop;
  logic [DATA_WIDTH-1:0] d_head [FLUX];
  logic [DATA_WIDTH-1:0] n_head [FLUX];

  logic [1:0]            state_q, state_d;
  logic [TAG_WIDTH-1:0]  sel_q, sel_d;
  logic [TAG_WIDTH-1:0]  rr_q, rr_d;
  logic [DATA_WIDTH-1:0] k_q, k_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [FLUX-1:0]       ovf_q, ovf_d;

  logic                  grant_vld;
  logic [TAG_WIDTH-1:0]  grant_idx;
  logic [TAG_WIDTH-1:0]  cand;

  assign d_tag = in_port_datain[WIDTH-1 -: TAG_WIDTH];
  assign n_tag = in_port_datain_nda[WIDTH-1 -: TAG_WIDTH];

  // One data FIFO and one control FIFO per flux; tags with no matching flux hit nothing.
  for (genvar f = 0; f < FLUX; f++) begin : g_flux
    logic d_hit, n_hit;
    assign d_hit = in_port_write     && (d_tag == TAG_WIDTH'(f));
    assign n_hit = in_port_write_nda && (n_tag == TAG_WIDTH'(f));

    ddf_pick_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_data (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (d_hit),
      .wr_data (in_port_datain[DATA_WIDTH-1:0]),
      .rd_en   (d_pop[f]),
      .rd_data (d_head[f]),
      .full    (d_full[f]),
      .empty   (d_empty[f]),
      .drop    (d_drop[f])
    );

    ddf_pick_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_nda (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (n_hit),
      .wr_data (in_port_datain_nda[DATA_WIDTH-1:0]),
      .rd_en   (n_pop[f]),
      .rd_data (n_head[f]),
      .full    (n_full[f]),
      .empty   (n_empty[f]),
      .drop    (n_drop[f])
    );
  end

  // Round-robin search: first flux at or after rr with a pending control token.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < FLUX; i++) begin
      cand = TAG_WIDTH'((int'(rr_q) + i) % FLUX);
      if (!grant_vld && !n_empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Pick FSM: grant a flux, reduce K of its data tokens, hold the result until accepted.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    n_pop   = '0;
    d_pop   = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          n_pop[grant_idx] = 1'b1;
          sel_d = grant_idx;
          k_d   = n_head[grant_idx];
          cnt_d = '0;
          acc_d = '0;
          rr_d  = (grant_idx == TAG_WIDTH'(FLUX - 1)) ? '0 : grant_idx + TAG_WIDTH'(1);
          if (n_head[grant_idx] != '0) state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // The locked flux waits indefinitely for data; no other flux can preempt it.
        if (!d_empty[sel_q]) begin
          d_pop[sel_q] = 1'b1;
          if (MODE == 0) acc_d = acc_q + d_head[sel_q];
          else           acc_d = (d_head[sel_q] > acc_q) ? d_head[sel_q] : acc_q;
          cnt_d = cnt_q + DATA_WIDTH'(1);
          if (cnt_d == k_q) state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (!out_port_full) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky per-flux overflow from either FIFO of the flux.
  always_comb begin
    ovf_d = ovf_q | d_drop | n_drop;
  end

  // FSM and datapath registers; reset aborts any pick in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_port_full     = d_full;
  assign in_port_full_nda = n_full;
  assign overflow         = ovf_q;
  assign out_port_write   = (state_q == ST_EMIT) && !out_port_full;
  assign out_port_dataout = (state_q == ST_EMIT) ? {sel_q, acc_q} : '0;
  assign dbg_state        = state_q;
endmodule
